// File: rtl/move_controller_pkg.sv
// Shared enums, constants and helpers for the board/move logic.
// Imported by the move controller and its cursor sub-block.
package common_enums;

  typedef enum logic [1:0] {
    START_SCREEN,
    GAME_SCREEN,
    END_SCREEN
  } screen_state_t;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_SEL_SRC,
    MC_SEL_DST,
    MC_COMMIT_DST,
    MC_COMMIT_SRC,
    MC_DONE
  } mc_state_t;

  localparam logic [3:0] PIECE_EMPTY = 4'd15;

  // Player 1 owns codes 0-5, player 0 owns 6-11.
  function automatic logic is_own_piece(
    input logic [3:0] piece,
    input logic       player
  );
    if (player) return piece <= 4'd5;
    return (piece >= 4'd6) && (piece <= 4'd11);
  endfunction

  function automatic logic [63:0] sq_mask(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return 64'd1 << {r, c};
  endfunction

endpackage

// File: rtl/move_controller_if.sv
// Board write port and committed-move report of the move controller.
// master drives it, the board/turn logic listens.
interface move_controller_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [3:0] wr_piece;
  logic       move_done;
  logic [5:0] move_from;
  logic [5:0] move_to;

  modport master (
    output wr_en, wr_row, wr_col, wr_piece,
    output move_done, move_from, move_to
  );

  modport slave (
    input wr_en, wr_row, wr_col, wr_piece,
    input move_done, move_from, move_to
  );
endinterface

// File: rtl/move_controller_cursor.sv
// Board cursor: row/col registers with wrap, key priority and load.
// Exposes next-cycle position so registered overlays stay aligned.
module cursor_ctrl
  import common_enums::*;
#(
  parameter int CURSOR_ROW_RST = 7,
  parameter int CURSOR_COL_RST = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       en,
  input  logic       load,
  input  logic       dir,
  input  logic       key1out,
  input  logic       key2out,
  input  logic       key3out,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic [2:0] row_nxt,
  output logic [2:0] col_nxt
);
  localparam logic [2:0] ROW0 = CURSOR_ROW_RST[2:0];
  localparam logic [2:0] COL0 = CURSOR_COL_RST[2:0];

  // Enter outranks the step keys; 3-bit add wraps on its own.
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (load) begin
      row_nxt = ROW0;
      col_nxt = COL0;
    end else if (en && !key3out) begin
      if (key1out) begin
        if (dir) row_nxt = row + 3'd1;
        else     col_nxt = col + 3'd1;
      end else if (key2out) begin
        if (dir) row_nxt = row - 3'd1;
        else     col_nxt = col - 3'd1;
      end
    end
  end

  // Cursor position register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      row <= ROW0;
      col <= COL0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end
endmodule

// File: rtl/move_controller.sv
// Local move sequencer: cursor, source/dest select, two-write commit.
// All outputs are registered from next-cycle values.
module move_controller
  import common_enums::*;
#(
  parameter int CURSOR_ROW_RST = 7,
  parameter int CURSOR_COL_RST = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  screen_state_t       state,
  input  logic                player,
  input  logic                curr_player,
  input  logic                dir,
  input  logic                key1out,
  input  logic                key2out,
  input  logic                key3out,
  input  logic [3:0]          board_in [8][8],
  move_controller_if.master   bus,
  output logic [7:0][7:0]     square_highlight
);
  mc_state_t  st, nxt;
  logic [2:0] cur_r, cur_c, cur_r_n, cur_c_n;
  logic [2:0] src_r, src_c, src_r_n, src_c_n;
  logic [2:0] dst_r, dst_c, dst_r_n, dst_c_n;
  logic [3:0] piece, piece_n, cur_piece;
  logic       src_v, src_v_n;
  logic       active, sel, on_src, own;

  assign active = (state == GAME_SCREEN) &&
                  (curr_player == player);
  assign sel = (st == MC_SEL_SRC) || (st == MC_SEL_DST);
  assign cur_piece = board_in[cur_r][cur_c];
  assign own = is_own_piece(cur_piece, player);
  assign on_src = src_v && (cur_r == src_r) &&
                  (cur_c == src_c);

  cursor_ctrl #(
    .CURSOR_ROW_RST(CURSOR_ROW_RST),
    .CURSOR_COL_RST(CURSOR_COL_RST)
  ) u_cursor (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .en       (sel),
    .load     ((st == MC_IDLE) && active),
    .dir      (dir),
    .key1out  (key1out),
    .key2out  (key2out),
    .key3out  (key3out),
    .row      (cur_r),
    .col      (cur_c),
    .row_nxt  (cur_r_n),
    .col_nxt  (cur_c_n)
  );

  // Next state and selection latches; commit is never aborted.
  always_comb begin
    nxt     = st;
    src_r_n = src_r;
    src_c_n = src_c;
    src_v_n = src_v;
    dst_r_n = dst_r;
    dst_c_n = dst_c;
    piece_n = piece;
    unique case (st)
      MC_IDLE: if (active) nxt = MC_SEL_SRC;
      MC_SEL_SRC, MC_SEL_DST: begin
        if (!active) begin
          nxt     = MC_IDLE;
          src_v_n = 1'b0;
        end else if (key3out) begin
          if (st == MC_SEL_DST && on_src) begin
            nxt     = MC_SEL_SRC;
            src_v_n = 1'b0;
          end else if (own) begin
            nxt     = MC_SEL_DST;
            src_r_n = cur_r;
            src_c_n = cur_c;
            src_v_n = 1'b1;
            piece_n = cur_piece;
          end else if (st == MC_SEL_DST) begin
            nxt     = MC_COMMIT_DST;
            dst_r_n = cur_r;
            dst_c_n = cur_c;
          end
        end
      end
      MC_COMMIT_DST: nxt = MC_COMMIT_SRC;
      MC_COMMIT_SRC: nxt = MC_DONE;
      MC_DONE: begin
        nxt     = MC_IDLE;
        src_v_n = 1'b0;
      end
      default: nxt = MC_IDLE;
    endcase
  end

  // State and selection registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      st    <= MC_IDLE;
      src_r <= '0;
      src_c <= '0;
      src_v <= 1'b0;
      dst_r <= '0;
      dst_c <= '0;
      piece <= '0;
    end else begin
      st    <= nxt;
      src_r <= src_r_n;
      src_c <= src_c_n;
      src_v <= src_v_n;
      dst_r <= dst_r_n;
      dst_c <= dst_c_n;
      piece <= piece_n;
    end
  end

  // Registered write port, move report and highlight overlay.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_en        <= 1'b0;
      bus.wr_row       <= '0;
      bus.wr_col       <= '0;
      bus.wr_piece     <= '0;
      bus.move_done    <= 1'b0;
      bus.move_from    <= '0;
      bus.move_to      <= '0;
      square_highlight <= '0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.wr_row    <= '0;
      bus.wr_col    <= '0;
      bus.wr_piece  <= '0;
      bus.move_done <= (nxt == MC_DONE);
      if (nxt == MC_COMMIT_DST) begin
        bus.wr_en    <= 1'b1;
        bus.wr_row   <= dst_r_n;
        bus.wr_col   <= dst_c_n;
        bus.wr_piece <= piece_n;
      end else if (nxt == MC_COMMIT_SRC) begin
        bus.wr_en    <= 1'b1;
        bus.wr_row   <= src_r_n;
        bus.wr_col   <= src_c_n;
        bus.wr_piece <= PIECE_EMPTY;
      end
      if (nxt == MC_DONE) begin
        bus.move_from <= {src_r_n, src_c_n};
        bus.move_to   <= {dst_r_n, dst_c_n};
      end
      if (nxt == MC_IDLE)
        square_highlight <= '0;
      else
        square_highlight <= sq_mask(cur_r_n, cur_c_n) |
          (src_v_n ? sq_mask(src_r_n, src_c_n) : 64'd0);
    end
  end
endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed plan plus random play,
// checked every cycle against a behavioural move model.
module tb_move_controller;
  import common_enums::*;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n = 1'b0;
  screen_state_t state = START_SCREEN;
  logic          player = 1'b1;
  logic          curr_player = 1'b1;
  logic          dir = 1'b0;
  logic          key1out = 1'b0;
  logic          key2out = 1'b0;
  logic          key3out = 1'b0;
  logic [3:0]    board_in [8][8];
  logic [7:0][7:0] square_highlight;

  move_controller_if bus();

  move_controller dut (
    .CLOCK_50         (CLOCK_50),
    .reset_n          (reset_n),
    .state            (state),
    .player           (player),
    .curr_player      (curr_player),
    .dir              (dir),
    .key1out          (key1out),
    .key2out          (key2out),
    .key3out          (key3out),
    .board_in         (board_in),
    .bus              (bus),
    .square_highlight (square_highlight)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int pass_n = 0;
  int total_n = 0;

  typedef struct {
    int we; int r; int c; int p; int done; int leave;
  } ev_t;
  ev_t q[$];

  int          m_play, m_have;
  int          m_r, m_c, m_sr, m_sc, m_dr, m_dc, m_piece;
  logic [5:0]  m_from, m_to;
  int          e_we, e_r, e_c, e_p, e_done;
  logic [63:0] e_hl;

  function automatic logic [63:0] sq(input int r, input int c);
    return 64'd1 << (r * 8 + c);
  endfunction

  function automatic int owns(input int p, input logic pl);
    if (pl) return int'(p >= 0 && p <= 5);
    return int'(p >= 6 && p <= 11);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_play = 0; m_have = 0; m_r = 7; m_c = 4;
    m_sr = 0; m_sc = 0; m_dr = 0; m_dc = 0; m_piece = 0;
    m_from = '0; m_to = '0;
    q.delete();
    e_we = 0; e_r = 0; e_c = 0; e_p = 0; e_done = 0; e_hl = '0;
  endtask

  task automatic apply_ev(input ev_t ev);
    e_we = ev.we; e_r = ev.r; e_c = ev.c; e_p = ev.p;
    e_done = ev.done;
    if (ev.done != 0) begin
      m_from = 6'(m_sr * 8 + m_sc);
      m_to   = 6'(m_dr * 8 + m_dc);
    end
    if (ev.leave != 0) begin
      m_play = 0; m_have = 0;
    end
  endtask

  task automatic model_step();
    int p;
    bit go;
    go = (state == GAME_SCREEN) && (curr_player == player);
    e_we = 0; e_r = 0; e_c = 0; e_p = 0; e_done = 0;
    if (q.size() > 0) begin
      apply_ev(q.pop_front());
    end else if (m_play == 0) begin
      if (go) begin
        m_play = 1; m_r = 7; m_c = 4;
      end
    end else if (!go) begin
      m_play = 0; m_have = 0;
    end else if (key3out) begin
      p = int'(board_in[m_r][m_c]);
      if (m_have == 0) begin
        if (owns(p, player) != 0) begin
          m_have = 1; m_sr = m_r; m_sc = m_c; m_piece = p;
        end
      end else if (m_r == m_sr && m_c == m_sc) begin
        m_have = 0;
      end else if (owns(p, player) != 0) begin
        m_sr = m_r; m_sc = m_c; m_piece = p;
      end else begin
        m_dr = m_r; m_dc = m_c;
        q.push_back('{1, m_dr, m_dc, m_piece, 0, 0});
        q.push_back('{1, m_sr, m_sc, 15, 0, 0});
        q.push_back('{0, 0, 0, 0, 1, 0});
        q.push_back('{0, 0, 0, 0, 0, 1});
        apply_ev(q.pop_front());
      end
    end else if (key1out) begin
      if (dir) m_r = (m_r + 1) % 8;
      else     m_c = (m_c + 1) % 8;
    end else if (key2out) begin
      if (dir) m_r = (m_r + 7) % 8;
      else     m_c = (m_c + 7) % 8;
    end
    if (m_play == 0) e_hl = '0;
    else e_hl = sq(m_r, m_c) | ((m_have != 0) ? sq(m_sr, m_sc) : 64'd0);
  endtask

  // One clock: model, board write-back, edge, compare.
  task automatic tick();
    if (!reset_n) model_reset();
    else model_step();
    if (bus.wr_en) board_in[bus.wr_row][bus.wr_col] = bus.wr_piece;
    @(posedge CLOCK_50);
    #1;
    chk("highlight", square_highlight, e_hl);
    chk("wr_en", 64'(bus.wr_en), 64'(e_we));
    if (e_we != 0) begin
      chk("wr_row", 64'(bus.wr_row), 64'(e_r));
      chk("wr_col", 64'(bus.wr_col), 64'(e_c));
      chk("wr_piece", 64'(bus.wr_piece), 64'(e_p));
    end
    chk("move_done", 64'(bus.move_done), 64'(e_done));
    chk("move_from", 64'(bus.move_from), 64'(m_from));
    chk("move_to", 64'(bus.move_to), 64'(m_to));
    key1out = 1'b0; key2out = 1'b0; key3out = 1'b0;
  endtask

  task automatic press(input int k, input logic d);
    dir = d;
    key1out = (k == 1); key2out = (k == 2); key3out = (k == 3);
    tick();
  endtask

  task automatic init_board();
    int r7 [8] = '{3, 1, 2, 0, 4, 2, 1, 3};
    int r0 [8] = '{9, 7, 8, 6, 10, 8, 7, 9};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (r == 0) board_in[r][c] = 4'(r0[c]);
        else if (r == 1) board_in[r][c] = 4'd11;
        else if (r == 6) board_in[r][c] = 4'd5;
        else if (r == 7) board_in[r][c] = 4'(r7[c]);
        else board_in[r][c] = 4'd15;
      end
  endtask

  initial begin
    init_board();
    model_reset();
    tick(); tick();
    chk("rst wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst done", 64'(bus.move_done), 64'd0);
    chk("rst hl", square_highlight, 64'd0);
    chk("rst wr_row", 64'(bus.wr_row), 64'd0);
    chk("rst from", 64'(bus.move_from), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("off-screen hl", square_highlight, 64'd0);
    state = GAME_SCREEN;
    tick();
    chk("enter hl", square_highlight, sq(7, 4));
    repeat (4) press(1, 1'b0);
    chk("wrap col+", square_highlight, sq(7, 0));
    repeat (3) press(2, 1'b0);
    chk("wrap col-", square_highlight, sq(7, 5));
    press(1, 1'b1);
    chk("wrap row+", square_highlight, sq(0, 5));
    press(2, 1'b1);
    press(2, 1'b0);
    press(3, 1'b0);
    chk("src hl", square_highlight, sq(7, 4));
    repeat (2) press(2, 1'b1);
    chk("dst hl", square_highlight, sq(5, 4) | sq(7, 4));
    press(3, 1'b0);
    chk("w1 en", 64'(bus.wr_en), 64'd1);
    chk("w1 addr", 64'({bus.wr_row, bus.wr_col}), 64'd44);
    chk("w1 piece", 64'(bus.wr_piece), 64'd4);
    tick();
    chk("w2 addr", 64'({bus.wr_row, bus.wr_col}), 64'd60);
    chk("w2 piece", 64'(bus.wr_piece), 64'd15);
    tick();
    chk("done", 64'(bus.move_done), 64'd1);
    chk("from", 64'(bus.move_from), 64'd60);
    chk("to", 64'(bus.move_to), 64'd44);
    tick();
    chk("idle hl", square_highlight, 64'd0);
    tick();
    chk("reenter hl", square_highlight, sq(7, 4));
    repeat (3) press(2, 1'b1);
    press(3, 1'b0);
    chk("empty sel", square_highlight, sq(4, 4));
    press(1, 1'b1);
    press(3, 1'b0);
    press(3, 1'b0);
    press(1, 1'b1);
    chk("cancel hl", square_highlight, sq(6, 4));
    dir = 1'b1; key1out = 1'b1; key3out = 1'b1;
    tick();
    chk("k1k3 hl", square_highlight, sq(6, 4));
    press(2, 1'b1);
    chk("k1k3 sel", square_highlight, sq(5, 4) | sq(6, 4));
    curr_player = 1'b0;
    tick();
    chk("turn lost", square_highlight, 64'd0);
    curr_player = 1'b1;
    tick();
    press(2, 1'b0);
    press(3, 1'b0);
    repeat (3) press(2, 1'b1);
    press(3, 1'b0);
    chk("c1 addr", 64'({bus.wr_row, bus.wr_col}), 64'd35);
    curr_player = 1'b0;
    tick();
    chk("c2 en", 64'(bus.wr_en), 64'd1);
    chk("c2 addr", 64'({bus.wr_row, bus.wr_col}), 64'd59);
    tick();
    chk("c done", 64'(bus.move_done), 64'd1);
    chk("c to", 64'(bus.move_to), 64'd35);
    tick();
    curr_player = 1'b1;
    tick();
    press(2, 1'b1);
    press(3, 1'b0);
    repeat (2) press(2, 1'b1);
    press(3, 1'b0);
    chk("pre-rst wr", 64'(bus.wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async wr_en", 64'(bus.wr_en), 64'd0);
    chk("async hl", square_highlight, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0)
        state = (state == GAME_SCREEN) ? END_SCREEN : GAME_SCREEN;
      if ($urandom_range(0, 39) == 0) curr_player = ~curr_player;
      if ($urandom_range(0, 199) == 0) player = ~player;
      dir = 1'($urandom_range(0, 1));
      key1out = ($urandom_range(0, 3) == 0);
      key2out = ($urandom_range(0, 3) == 0);
      key3out = ($urandom_range(0, 4) == 0);
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/move_controller.md
# move_controller

Sequences the local player's move on the 8x8 board during play. It moves a cursor with the push-button pulses, selects a source and destination square, and commits the move as two single-square writes into the board datapath. It then pulses `move_done` so the turn/link logic can hand the turn over. It sits between the key debouncers and the board register array and feeds the highlight overlay to the renderer.

## Interface
Parameters:
- `CURSOR_ROW_RST`, default 7: cursor row after reset or on entering play.
- `CURSOR_COL_RST`, default 4: cursor column after reset or on entering play.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `state`  in  screen_state_t  screen state; the block is active only in `GAME_SCREEN`.
- `player`  in  1  local player's colour.
  - 1: owns piece codes 0–5.
  - 0: owns piece codes 6–11.
- `curr_player`  in  1  player whose turn it is; the local turn is `curr_player == player`.
- `dir`  in  1  cursor axis: 0 = column step, 1 = row step.
- `key1out`  in  1  one-cycle pulse: cursor + step.
- `key2out`  in  1  one-cycle pulse: cursor − step.
- `key3out`  in  1  one-cycle pulse: enter.
- `board_in`  in  [3:0] [8][8]  current board contents (15 = empty).
- `wr_en`  out  1  single-square write strobe to the board.
- `wr_row`, `wr_col`  out  3 each  write address.
- `wr_piece`  out  4  write data.
- `move_done`  out  1  one-cycle pulse after the commit completes.
- `move_from`, `move_to`  out  6 each  {row,col} of the last committed move; held until the next commit.
- `square_highlight`  out  [8][8]  1 = cursor square or selected source.

## Operation
States (`mc_state_t`): `MC_IDLE`, `MC_SEL_SRC`, `MC_SEL_DST`, `MC_COMMIT_DST`, `MC_COMMIT_SRC`, `MC_DONE`.

Entering and leaving play:
- `MC_IDLE` → `MC_SEL_SRC` when `state == GAME_SCREEN` and it is the local turn. The cursor loads `CURSOR_ROW_RST/COL_RST`.
- If `state` leaves `GAME_SCREEN` or the turn is lost while in `MC_SEL_SRC` or `MC_SEL_DST`, go to `MC_IDLE` next cycle and clear the source.
- Commit states are never aborted by `state`/turn changes.

Cursor movement (both select states only):
- key1: +1 if `dir`=0, column wraps 7→0 in the same row. +1 row if `dir`=1, row wraps 7→0.
- key2: the mirror image (0→7 wrap).

Key priority:
- Simultaneous keys: key3 > key1 > key2; only one action per cycle.

Selection:
- `MC_SEL_SRC` + key3: if `board_in[cursor]` is owned by the local player, latch the source and go to `MC_SEL_DST`. Otherwise ignore.
- `MC_SEL_DST` + key3:
  - On the source square: cancel, back to `MC_SEL_SRC`.
  - On another own piece: re-select, the source moves there.
  - Otherwise: latch the destination and go to `MC_COMMIT_DST`.
- No chess-legality check (that belongs to a later block).

Commit sequence:
- `MC_COMMIT_DST`: `wr_en`=1, address = destination, `wr_piece` = latched source piece.
- `MC_COMMIT_SRC`: `wr_en`=1, address = source, `wr_piece` = 15.
- `MC_DONE`: `move_done`=1, update `move_from`/`move_to`, → `MC_IDLE`.

Highlight:
- `square_highlight` is all-zero in `MC_IDLE`, otherwise cursor | source (when latched).

## Timing
- Reset values:
  - State `MC_IDLE`.
  - Cursor (7,4).
  - `wr_en`, `move_done` = 0.
  - `wr_row`, `wr_col`, `wr_piece`, `move_from`, `move_to` = 0.
  - `square_highlight` all 0.
- All outputs are registered.
- Latencies:
  - Cursor and highlight change one cycle after a key pulse.
  - Key3 at the destination at cycle N gives writes at N+1 and N+2 and `move_done` at N+3.
- `wr_*` is valid only while `wr_en`=1; `board_in` is ignored during commit.
- Asynchronous reset mid-commit abandons the move. The partially written board is the board block's concern.
- Keys arriving in commit/`MC_DONE`/`MC_IDLE` are dropped, not queued.

## Structure
- Add to `common_enums`:
  - `mc_state_t`.
  - `PIECE_EMPTY = 4'd15`.
  - Function `is_own_piece(piece, player)`.
- One sub-module, `cursor_ctrl`: row/col registers with wrap and key priority, plus enable and load inputs.
- The FSM, latches and write port stay in `move_controller`.

## Test plan
- Reset then `GAME_SCREEN`, `player`=1, `curr_player`=1 → `MC_SEL_SRC`, highlight only at (7,4).
- `dir`=0, three key2 pulses from (7,0) → cursor (7,5); `dir`=1, key1 from (7,5) → (0,5).
- Default board, `player`=1: key3 at (7,4) holding code 4 → source latched. Move to (5,4), key3 → `wr` (5,4)←4, then (7,4)←15, then `move_done`=1 with `move_from`=7,4 and `move_to`=5,4.
- key3 on empty (4,4) in `MC_SEL_SRC` → no state change. key3 on own source in `MC_SEL_DST` → back to `MC_SEL_SRC`, highlight cleared.
- `curr_player` toggles during `MC_SEL_DST` → `MC_IDLE`, highlight zero. Same toggle during `MC_COMMIT_DST` → both writes and `move_done` still occur.
- key1 and key3 in the same cycle in `MC_SEL_SRC` on an own piece → selection only, cursor unchanged.
